// File: rtl/market_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// market_pkg
// Shared constants, state encoding and helpers for the market frame receiver.
// Revision: 1.0
// ============================================================================
package market_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_KLINE = 8'h01;
   localparam logic [7:0] CMD_ACCT  = 8'h02;
   localparam int         KLINE_LEN = 80;
   localparam int         ACCT_LEN  = 1;

   localparam int         BUF_DEPTH = 128;
   localparam int         BUF_AW    = 7;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TYPE_LEN = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [2:0] {
      ST_HUNT       = 3'd0,
      ST_TYPE       = 3'd1,
      ST_LEN        = 3'd2,
      ST_PAYLOAD    = 3'd3,
      ST_CHK        = 3'd4,
      ST_REPLAY_CMD = 3'd5,
      ST_REPLAY     = 3'd6,
      ST_DRAIN      = 3'd7
   } rx_state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/market_frame_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// frame_buffer
// Payload store: one write port, one synchronous read port (1-cycle latency).
// Revision: 1.0
// ============================================================================
module frame_buffer
   import market_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] r_mem [BUF_DEPTH];
   logic [7:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/market_frame_rx.sv
`default_nettype none
// ============================================================================
// market_frame_rx
// Hunts, validates and buffers framed market packets; replays good frames.
// Revision: 1.0
// ============================================================================
module market_frame_rx #(
   parameter logic [7:0] SYNC_BYTE      = market_pkg::SYNC_BYTE,
   parameter int         KLINE_LEN      = market_pkg::KLINE_LEN,
   parameter int         ACCT_LEN       = market_pkg::ACCT_LEN,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter int         GAP            = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [8:0]  out_data,
   output logic        out_done,
   output logic        busy,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_err_cnt,
   output logic [15:0] overrun_cnt,
   output logic [1:0]  last_err
);
   import market_pkg::*;

   localparam int                 c_tmo_w     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int                 c_gap_w     = $clog2(GAP + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_max   = c_tmo_w'(TIMEOUT_CYCLES);
   localparam logic [c_gap_w-1:0] c_gap_max   = c_gap_w'(GAP);
   localparam logic [6:0]         c_kline_len = 7'(KLINE_LEN);
   localparam logic [6:0]         c_acct_len  = 7'(ACCT_LEN);

   rx_state_t           r_state, w_state_nxt;
   logic [7:0]          r_chk, w_chk_nxt;
   logic [7:0]          r_type, w_type_nxt;
   logic [6:0]          r_len, w_len_nxt;
   logic [6:0]          r_idx, w_idx_nxt;
   logic [c_tmo_w-1:0]  r_tmo, w_tmo_nxt;
   logic [c_gap_w-1:0]  r_gap, w_gap_nxt;
   logic [8:0]          r_out_data, w_out_data_nxt;
   logic                r_out_done, w_out_done_nxt;
   logic                r_busy;
   logic [15:0]         r_ok_cnt, w_ok_cnt_nxt;
   logic [15:0]         r_err_cnt, w_err_cnt_nxt;
   logic [15:0]         r_ovr_cnt, w_ovr_cnt_nxt;
   logic [1:0]          r_last_err, w_last_err_nxt;
   logic                w_wr_en;
   logic [7:0]          w_rd_data;
   logic                w_err;
   logic [1:0]          w_err_code;
   logic                w_len_ok;

   frame_buffer u_frame_buffer (
      .clk     (clk),
      .wr_en   (w_wr_en),
      .wr_addr (r_idx),
      .wr_data (rx_data),
      .rd_addr (r_idx),
      .rd_data (w_rd_data)
   );

   assign w_len_ok = ((r_type == CMD_KLINE) && (rx_data == {1'b0, c_kline_len})) ||
                     ((r_type == CMD_ACCT)  && (rx_data == {1'b0, c_acct_len}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_HUNT;
         r_chk      <= 8'd0;
         r_type     <= 8'd0;
         r_len      <= 7'd0;
         r_idx      <= 7'd0;
         r_tmo      <= '0;
         r_gap      <= '0;
         r_out_data <= 9'd0;
         r_out_done <= 1'b0;
         r_busy     <= 1'b0;
         r_ok_cnt   <= 16'd0;
         r_err_cnt  <= 16'd0;
         r_ovr_cnt  <= 16'd0;
         r_last_err <= ERR_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_chk      <= w_chk_nxt;
         r_type     <= w_type_nxt;
         r_len      <= w_len_nxt;
         r_idx      <= w_idx_nxt;
         r_tmo      <= w_tmo_nxt;
         r_gap      <= w_gap_nxt;
         r_out_data <= w_out_data_nxt;
         r_out_done <= w_out_done_nxt;
         r_busy     <= (w_state_nxt != ST_HUNT);
         r_ok_cnt   <= w_ok_cnt_nxt;
         r_err_cnt  <= w_err_cnt_nxt;
         r_ovr_cnt  <= w_ovr_cnt_nxt;
         r_last_err <= w_last_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_chk_nxt      = r_chk;
      w_type_nxt     = r_type;
      w_len_nxt      = r_len;
      w_idx_nxt      = r_idx;
      w_tmo_nxt      = r_tmo;
      w_gap_nxt      = r_gap;
      w_out_data_nxt = r_out_data;
      w_out_done_nxt = 1'b0;
      w_ok_cnt_nxt   = r_ok_cnt;
      w_err_cnt_nxt  = r_err_cnt;
      w_ovr_cnt_nxt  = r_ovr_cnt;
      w_last_err_nxt = r_last_err;
      w_wr_en        = 1'b0;
      w_err          = 1'b0;
      w_err_code     = ERR_NONE;

      case (r_state)
         ST_HUNT: begin
            w_tmo_nxt = '0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               w_state_nxt = ST_TYPE;
            end
         end

         ST_TYPE, ST_LEN, ST_PAYLOAD, ST_CHK: begin
            // Timeout wins over a byte landing in the same cycle.
            if (r_tmo == c_tmo_max) begin
               w_err      = 1'b1;
               w_err_code = ERR_TIMEOUT;
            end else if (!rx_valid) begin
               w_tmo_nxt = r_tmo + 1'b1;
            end else begin
               w_tmo_nxt = '0;
               case (r_state)
                  ST_TYPE: begin
                     if ((rx_data == CMD_KLINE) || (rx_data == CMD_ACCT)) begin
                        w_type_nxt  = rx_data;
                        w_chk_nxt   = rx_data;
                        w_state_nxt = ST_LEN;
                     end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_TYPE_LEN;
                     end
                  end
                  ST_LEN: begin
                     if (w_len_ok) begin
                        w_len_nxt   = rx_data[6:0];
                        w_chk_nxt   = r_chk ^ rx_data;
                        w_idx_nxt   = 7'd0;
                        w_state_nxt = ST_PAYLOAD;
                     end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_TYPE_LEN;
                     end
                  end
                  ST_PAYLOAD: begin
                     w_wr_en   = 1'b1;
                     w_chk_nxt = r_chk ^ rx_data;
                     w_idx_nxt = r_idx + 7'd1;
                     if ((r_idx + 7'd1) == r_len) begin
                        w_state_nxt = ST_CHK;
                     end
                  end
                  default: begin
                     if (rx_data == r_chk) begin
                        w_out_done_nxt = 1'b1;
                        w_out_data_nxt = {1'b0, r_type};
                        w_idx_nxt      = 7'd0;
                        w_gap_nxt      = '0;
                        w_state_nxt    = ST_REPLAY_CMD;
                     end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CHECKSUM;
                     end
                  end
               endcase
            end
         end

         ST_REPLAY_CMD, ST_REPLAY: begin
            if (rx_valid) begin
               w_ovr_cnt_nxt = sat_inc(r_ovr_cnt);
            end
            // r_idx has been stable for at least one cycle, so rd_data is buffer[r_idx].
            if (r_gap == c_gap_max) begin
               w_out_done_nxt = 1'b1;
               w_out_data_nxt = {1'b0, w_rd_data};
               w_idx_nxt      = r_idx + 7'd1;
               w_gap_nxt      = '0;
               w_state_nxt    = ((r_idx + 7'd1) == r_len) ? ST_DRAIN : ST_REPLAY;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end

         ST_DRAIN: begin
            if (rx_valid) begin
               w_ovr_cnt_nxt = sat_inc(r_ovr_cnt);
            end
            if (r_gap == c_gap_max) begin
               w_ok_cnt_nxt = sat_inc(r_ok_cnt);
               w_gap_nxt    = '0;
               w_state_nxt  = ST_HUNT;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_HUNT;
         end
      endcase

      if (w_err) begin
         w_err_cnt_nxt  = sat_inc(r_err_cnt);
         w_last_err_nxt = w_err_code;
         w_tmo_nxt      = '0;
         w_state_nxt    = ST_HUNT;
      end
   end

   assign out_data      = r_out_data;
   assign out_done      = r_out_done;
   assign busy          = r_busy;
   assign frame_ok_cnt  = r_ok_cnt;
   assign frame_err_cnt = r_err_cnt;
   assign overrun_cnt   = r_ovr_cnt;
   assign last_err      = r_last_err;

endmodule
`default_nettype wire

// File: tb/tb_market_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_market_frame_rx
// Directed self-checking bench for market_frame_rx.
// Revision: 1.0
// ============================================================================
module tb_market_frame_rx;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [8:0]  out_data;
   logic        out_done;
   logic        busy;
   logic [15:0] frame_ok_cnt;
   logic [15:0] frame_err_cnt;
   logic [15:0] overrun_cnt;
   logic [1:0]  last_err;

   int          total;
   int          bad;
   int          cyc;
   int          n_cyc;
   logic [8:0]  q_data [$];
   int          q_cyc  [$];

   market_frame_rx #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .out_data      (out_data),
      .out_done      (out_done),
      .busy          (busy),
      .frame_ok_cnt  (frame_ok_cnt),
      .frame_err_cnt (frame_err_cnt),
      .overrun_cnt   (overrun_cnt),
      .last_err      (last_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_done) begin
         q_data.push_back(out_data);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q_data.delete();
      q_cyc.delete();
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq("idle_reached", busy, 0);
   endtask

   task automatic send_acct(input logic [7:0] d, input logic [7:0] c);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(d);
      send_byte(c);
   endtask

   // Payload 0x00..0x4F; 0x01 ^ 0x50 ^ (XOR of 0..79 = 0) gives checksum 0x51.
   task automatic send_kline_head(input int n_payload);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h50);
      for (int i = 0; i < n_payload; i++) send_byte(8'(i));
   endtask

   task automatic check_kline_replay();
      check_eq("kline_count", q_data.size(), 81);
      for (int i = 0; i < q_data.size() && i < 81; i++) begin
         check_eq($sformatf("kline_data%0d", i), q_data[i], (i == 0) ? 9'h001 : 9'(i - 1));
         check_eq($sformatf("kline_cyc%0d", i), q_cyc[i], n_cyc + 3 * i);
      end
   endtask

   initial begin
      int n;
      total    = 0;
      bad      = 0;
      cyc      = 0;
      n_cyc    = 0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_done", out_done, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ok", frame_ok_cnt, 0);
      check_eq("rst_err", frame_err_cnt, 0);
      check_eq("rst_ovr", overrun_cnt, 0);
      check_eq("rst_last_err", last_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Valid K-line frame with strobe spacing
      send_byte(8'hA5);
      check_eq("busy_after_sync", busy, 1);
      send_byte(8'h01);
      send_byte(8'h50);
      for (int i = 0; i < 80; i++) send_byte(8'(i));
      send_byte(8'h51);
      n_cyc = cyc;
      wait_idle(400);
      check_kline_replay();
      check_eq("t1_ok", frame_ok_cnt, 1);
      check_eq("t1_err", frame_err_cnt, 0);

      // Valid account frame
      do_reset();
      send_acct(8'hEC, 8'hEF);
      wait_idle(50);
      check_eq("t2_count", q_data.size(), 2);
      if (q_data.size() == 2) begin
         check_eq("t2_cmd", q_data[0], 9'h002);
         check_eq("t2_byte", q_data[1], 9'h0EC);
      end
      check_eq("t2_ok", frame_ok_cnt, 1);

      // Checksum error, then recovery
      do_reset();
      send_acct(8'hEC, 8'h00);
      repeat (20) @(negedge clk);
      check_eq("t3_no_out", q_data.size(), 0);
      check_eq("t3_err", frame_err_cnt, 1);
      check_eq("t3_last_err", last_err, 2);
      check_eq("t3_busy", busy, 0);
      send_acct(8'hEC, 8'hEF);
      wait_idle(50);
      check_eq("t3_recover_count", q_data.size(), 2);
      check_eq("t3_ok", frame_ok_cnt, 1);

      // Bad length, garbage between frames
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h4F);
      check_eq("t4_last_err", last_err, 1);
      check_eq("t4_err", frame_err_cnt, 1);
      check_eq("t4_busy", busy, 0);
      send_byte(8'h12);
      send_byte(8'h34);
      check_eq("t4_garbage_err", frame_err_cnt, 1);
      check_eq("t4_garbage_ok", frame_ok_cnt, 0);
      check_eq("t4_garbage_busy", busy, 0);
      check_eq("t4_no_out", q_data.size(), 0);
      send_acct(8'h33, 8'h30);
      wait_idle(50);
      check_eq("t4_ok", frame_ok_cnt, 1);

      // Timeout after 40 payload bytes
      do_reset();
      send_kline_head(40);
      repeat (100) @(negedge clk);
      check_eq("t5_busy_before_tmo", busy, 1);
      @(negedge clk);
      check_eq("t5_busy_after_tmo", busy, 0);
      check_eq("t5_last_err", last_err, 3);
      check_eq("t5_err", frame_err_cnt, 1);
      check_eq("t5_no_out", q_data.size(), 0);
      send_acct(8'h55, 8'h56);
      wait_idle(50);
      check_eq("t5_ok", frame_ok_cnt, 1);
      check_eq("t5_count", q_data.size(), 2);

      // Overrun during replay
      do_reset();
      send_kline_head(80);
      send_byte(8'h51);
      n_cyc = cyc;
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h34);
      wait_idle(400);
      check_kline_replay();
      check_eq("t6_ovr", overrun_cnt, 3);
      check_eq("t6_ok", frame_ok_cnt, 1);

      // Reset pulsed while payload byte 20 is on the output
      send_kline_head(80);
      send_byte(8'h51);
      n = 0;
      while (!(out_done && out_data == 9'h014) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("t6_saw_byte20", out_done, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_done", out_done, 0);
      check_eq("t6_rst_data", out_data, 0);
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_ok", frame_ok_cnt, 0);
      check_eq("t6_rst_ovr", overrun_cnt, 0);
      check_eq("t6_rst_err", frame_err_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      q_data.delete();
      q_cyc.delete();
      repeat (300) @(negedge clk);
      check_eq("t6_no_continue", q_data.size(), 0);
      check_eq("t6_idle_busy", busy, 0);
      send_acct(8'hEC, 8'hEF);
      wait_idle(50);
      check_eq("t6_after_count", q_data.size(), 2);
      check_eq("t6_after_ok", frame_ok_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
